// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end: state encoding,
// reset address and small PC helpers.
package if_pkg;

    localparam int INSTR_W = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    localparam logic [1:0] ST_REQ  = S_REQ;
    localparam logic [1:0] ST_WAIT = S_WAIT;
    localparam logic [1:0] ST_DROP = S_DROP;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Modulo-2^32, so the last word of the address space wraps to zero.
    function automatic logic [31:0] pc_plus4(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding imem
// requests and holds one fetched word until IF/ID takes it.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_gnt,
    input  logic                 imem_rvalid,
    input  logic [INSTR_W-1:0]   imem_rdata,
    output logic [31:0]          pc_4,
    output logic [INSTR_W-1:0]   instr,
    output logic                 if_valid
);

    logic [1:0]          state_reg, state_next;
    logic [31:0]         pc_reg, pc_next;
    logic [31:0]         req_pc_reg, req_pc_next;
    logic [31:0]         pc_4_reg, pc_4_next;
    logic [INSTR_W-1:0]  instr_reg, instr_next;
    logic                if_valid_reg, if_valid_next;
    logic                armed_reg, armed_next;

    logic                consume;
    logic                req_raw;
    logic                granted;
    logic [31:0]         rsp_pc_4;

    // A request goes out only when the buffer is empty or being drained this
    // cycle, so a returning word always finds the buffer free.
    always_comb begin
        consume  = if_valid_reg & ~stall;
        req_raw  = (state_reg == ST_REQ) & (armed_reg | ~if_valid_reg | ~stall);
        granted  = req_raw & imem_gnt;
        rsp_pc_4 = pc_plus4(req_pc_reg);
    end

    assign imem_req  = req_raw & ~rst;
    assign imem_addr = pc_reg;
    assign pc_4      = pc_4_reg;
    assign instr     = instr_reg;
    assign if_valid  = if_valid_reg;

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        req_pc_next   = req_pc_reg;
        pc_4_next     = pc_4_reg;
        instr_next    = instr_reg;
        if_valid_next = if_valid_reg & ~consume;
        armed_next    = armed_reg;

        case (state_reg)
            ST_REQ: begin
                if (granted) begin
                    req_pc_next = pc_reg;
                    armed_next  = 1'b0;
                    state_next  = ST_WAIT;
                end else if (req_raw) begin
                    armed_next  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    pc_4_next     = rsp_pc_4;
                    instr_next    = imem_rdata;
                    if_valid_next = 1'b1;
                    pc_next       = rsp_pc_4;
                    state_next    = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_next = ST_REQ;
                end
            end
            default: begin
                state_next = ST_REQ;
            end
        endcase

        // Redirect wins over everything above; any word landing now is stale.
        if (redirect) begin
            pc_next       = word_align(redirect_pc);
            pc_4_next     = pc_4_reg;
            instr_next    = instr_reg;
            if_valid_next = 1'b0;
            armed_next    = 1'b0;
            case (state_reg)
                ST_REQ:  state_next = granted ? ST_DROP : ST_REQ;
                ST_WAIT: state_next = imem_rvalid ? ST_REQ : ST_DROP;
                ST_DROP: state_next = imem_rvalid ? ST_REQ : ST_DROP;
                default: state_next = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_REQ;
            pc_reg       <= RESET_PC;
            req_pc_reg   <= RESET_PC;
            pc_4_reg     <= '0;
            instr_reg    <= '0;
            if_valid_reg <= 1'b0;
            armed_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            req_pc_reg   <= req_pc_next;
            pc_4_reg     <= pc_4_next;
            instr_reg    <= instr_next;
            if_valid_reg <= if_valid_next;
            armed_reg    <= armed_next;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus a randomized run, all
// checked against an address-stream model of the fetch front end.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] pc_4;
    logic [31:0] instr;
    logic        if_valid;

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc_4        (pc_4),
        .instr       (instr),
        .if_valid    (if_valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: expected next granted address, expected next consumed
    // address, and the memory's single pending response.
    logic [31:0] mem_key = '0;
    logic [31:0] exp_grant, exp_cons;
    bit          mem_pend;
    int          mem_cnt;
    logic [31:0] mem_addr;
    bit          prev_hold, prev_redir, prev_shold;
    logic [31:0] prev_addr, prev_pc4, prev_instr;
    bit          cyc_gnt;
    int          ncons = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ mem_key;
    endfunction

    task automatic model_reset();
        mem_pend   = 0;
        mem_cnt    = 0;
        prev_hold  = 0;
        prev_redir = 0;
        prev_shold = 0;
        exp_grant  = RST_PC;
        exp_cons   = RST_PC;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1; stall = 0; redirect = 0; redirect_pc = '0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", if_valid, 0);
        check("rst_pc_4", pc_4, 0);
        check("rst_instr", instr, 0);
        repeat (2) @(negedge clk);
        check("rst_req_held", imem_req, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    // One clock cycle: drive inputs, let memory respond, check, advance model.
    task automatic step(input bit st, input bit rd, input logic [31:0] tgt,
                        input bit gnt_ok, input int lat);
        bit delivered;
        @(negedge clk);
        stall = st; redirect = rd; redirect_pc = tgt;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        delivered = 0;
        if (mem_pend && mem_cnt == 0) begin
            imem_rvalid = 1;
            imem_rdata  = mem_word(mem_addr);
            delivered   = 1;
        end
        #1;
        if (imem_req && gnt_ok) imem_gnt = 1;
        #1;
        cyc_gnt = imem_gnt;

        if (prev_hold) begin
            check("req_hold", imem_req, 1);
            check("addr_hold", imem_addr, prev_addr);
        end
        if (prev_redir) check("valid_after_redirect", if_valid, 0);
        if (prev_shold) begin
            check("stall_valid", if_valid, 1);
            check("stall_pc_4", pc_4, prev_pc4);
            check("stall_instr", instr, prev_instr);
        end
        if (imem_req) check("single_outstanding", mem_pend, 0);
        if (if_valid && !st) begin
            check("cons_pc_4", pc_4, exp_cons + 32'd4);
            check("cons_instr", instr, mem_word(exp_cons));
            $display("txn %0d: pc_4=%h instr=%h", ncons, pc_4, instr);
            exp_cons = exp_cons + 32'd4;
            ncons++;
        end
        if (imem_gnt) check("grant_addr", imem_addr, exp_grant);

        if (delivered) mem_pend = 0;
        else if (mem_pend) mem_cnt--;
        if (imem_gnt) begin
            mem_pend  = 1;
            mem_addr  = imem_addr;
            mem_cnt   = (lat < 1) ? 0 : lat - 1;
            exp_grant = imem_addr + 32'd4;
        end
        if (rd) begin
            exp_grant = tgt & 32'hFFFF_FFFC;
            exp_cons  = tgt & 32'hFFFF_FFFC;
        end
        prev_hold  = imem_req && !imem_gnt && !rd;
        prev_addr  = imem_addr;
        prev_redir = rd;
        prev_shold = if_valid && st && !rd;
        prev_pc4   = pc_4;
        prev_instr = instr;
    endtask

    bit          zw_req[6]   = '{1, 0, 1, 0, 1, 0};
    bit          zw_valid[6] = '{0, 0, 1, 0, 1, 0};
    logic [31:0] zw_addr[6]  = '{32'hBFC0_0000, 0, 32'hBFC0_0004, 0, 32'hBFC0_0008, 0};
    logic [31:0] zw_pc4[6]   = '{0, 0, 32'hBFC0_0004, 0, 32'hBFC0_0008, 0};
    logic [31:0] zw_ins[6]   = '{0, 0, 32'hBFC0_0000, 0, 32'hBFC0_0004, 0};

    initial begin
        bit          found;
        int          g_during;
        bit          st_r, rd_r, gn_r;
        logic [31:0] tgt_r;

        model_reset();
        do_reset();

        // Zero-wait memory returning instr = address
        for (int c = 0; c < 6; c++) begin
            step(0, 0, '0, 1, 1);
            check($sformatf("zw_req%0d", c), imem_req, zw_req[c]);
            check($sformatf("zw_valid%0d", c), if_valid, zw_valid[c]);
            if (zw_req[c]) check($sformatf("zw_addr%0d", c), imem_addr, zw_addr[c]);
            if (zw_valid[c]) begin
                check($sformatf("zw_pc_4_%0d", c), pc_4, zw_pc4[c]);
                check($sformatf("zw_instr%0d", c), instr, zw_ins[c]);
            end
        end

        // Stall held while the buffer is full
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 0, '0, 1, 1);
            found = if_valid;
        end
        check("stall_fill_timeout", found, 1);
        g_during = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 0, '0, 1, 1);
            if (cyc_gnt) g_during++;
        end
        check("stall_grants", g_during <= 1, 1);
        for (int i = 0; i < 10; i++) step(0, 0, '0, 1, 1);

        // Grant withheld while stall toggles
        step(0, 1, 32'h0000_2000, 0, 1);
        for (int i = 0; i < 6; i++) step(bit'(i % 2), 0, '0, 0, 1);
        check("delayed_req", imem_req, 1);
        check("delayed_addr", imem_addr, 32'h0000_2000);
        step(0, 0, '0, 1, 3);
        check("delayed_granted", cyc_gnt, 1);

        // Redirect in WAIT; the response two cycles later is discarded
        step(0, 1, 32'h0000_1002, 1, 1);
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 1);
        check("drop_valid", if_valid, 0);
        step(0, 0, '0, 0, 1);
        check("wait_redir_req", imem_req, 1);
        check("wait_redir_addr", imem_addr, 32'h0000_1000);
        check("wait_redir_valid", if_valid, 0);

        // Redirect coincident with grant
        step(0, 1, 32'h0000_3000, 1, 1);
        check("gnt_redir_granted", cyc_gnt, 1);
        step(0, 0, '0, 0, 1);
        check("gnt_redir_valid", if_valid, 0);
        step(0, 0, '0, 1, 1);
        check("gnt_redir_req", imem_req, 1);
        check("gnt_redir_addr", imem_addr, 32'h0000_3000);

        // Redirect coincident with rvalid
        step(0, 1, 32'h0000_4000, 0, 1);
        step(0, 0, '0, 0, 1);
        check("rv_redir_req", imem_req, 1);
        check("rv_redir_addr", imem_addr, 32'h0000_4000);
        check("rv_redir_valid", if_valid, 0);

        // Fetch of the last word wraps to zero
        step(0, 1, 32'hFFFF_FFFE, 0, 1);
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(0, 0, '0, 1, 1);
            found = if_valid;
        end
        check("wrap_timeout", found, 1);
        check("wrap_pc_4", pc_4, 32'h0000_0000);
        check("wrap_instr", instr, 32'hFFFF_FFFC);
        check("wrap_req", imem_req, 1);
        check("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset while waiting on a response
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 3);
        check("pre_rst_granted", cyc_gnt, 1);
        step(0, 0, '0, 0, 1);
        check("pre_rst_pc_4", pc_4, 32'h0000_0004);
        do_reset();
        step(0, 0, '0, 0, 1);
        check("post_rst_req", imem_req, 1);
        check("post_rst_addr", imem_addr, RST_PC);

        // Randomized traffic
        do_reset();
        mem_key = $urandom;
        for (int i = 0; i < 2500; i++) begin
            st_r = ($urandom % 100) < 30;
            rd_r = ($urandom % 100) < 4;
            gn_r = ($urandom % 100) < 65;
            if ($urandom % 8 == 0) tgt_r = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
            else tgt_r = $urandom;
            step(st_r, rd_r, tgt_r, gn_r, 1 + int'($urandom % 3));
        end
        check("progress", ncons > 100, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end that produces the `pc_4` / `instr` pair consumed by the IF/ID pipeline register. It owns the PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake. It holds each fetched word in a one-entry output buffer until IF/ID accepts it, and squashes in-flight fetches on a branch/jump redirect.

## Interface
- `RESET_PC`, default 32'hBFC0_0000 — PC value after reset.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  IF/ID hold; IF/ID loads only when `stall`=0.
- `redirect`  in  1  branch/jump taken; one-cycle pulse.
- `redirect_pc`  in  32  new fetch address; bits [1:0] ignored (forced 00).
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, word aligned.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  read data valid; at most one per accepted request, no earlier than the cycle after `imem_gnt`.
- `imem_rdata`  in  32  instruction word.
- `pc_4`  out  32  fetched PC + 4.
- `instr`  out  32  fetched instruction.
- `if_valid`  out  1  output buffer holds a valid instruction. When 0, IF/ID must load a bubble.

## Operation
- Registers:
  - `pc` is the next address to fetch.
  - `req_pc` is the address of the outstanding request.
  - Output buffer holds {`pc_4`, `instr`, `if_valid`}.
  - `armed` flag.
  - FSM state.
- States:
  - REQ: ready to issue a request.
  - WAIT: granted, awaiting `imem_rvalid`.
  - DROP: granted but squashed; discard the next `imem_rvalid`.
- Consume: a cycle with `if_valid`=1 and `stall`=0. On consume, `if_valid` clears next cycle unless the buffer is refilled.
- REQ:
  - `imem_req` = `armed` | !`if_valid` | !`stall`.
  - `imem_addr` = `pc`.
  - If `imem_req`=1 and `imem_gnt`=0, set `armed`. Once asserted, `imem_req` and `imem_addr` stay stable until `imem_gnt`.
  - On `imem_gnt`: `req_pc`<=`pc`, clear `armed`, go to WAIT.
- WAIT:
  - `imem_req`=0.
  - On `imem_rvalid`: `pc_4`<=`req_pc`+4, `instr`<=`imem_rdata`, `if_valid`<=1, `pc`<=`req_pc`+4, go to REQ.
  - The buffer is always free at this point, because a request is only issued when the buffer is empty or being consumed.
- DROP:
  - `imem_req`=0.
  - On `imem_rvalid`: discard the data, go to REQ.
- Redirect (highest priority; overrides any concurrent buffer update):
  - `pc`<=`{redirect_pc[31:2],2'b00}`, `if_valid`<=0, clear `armed`.
  - From REQ without `imem_gnt`: stay in REQ. The request may drop this cycle. The abandoned-but-ungranted request is legal only on redirect.
  - From REQ with `imem_gnt` in the same cycle: go to DROP.
  - From WAIT without `imem_rvalid`: go to DROP.
  - From WAIT with `imem_rvalid` in the same cycle: discard the data, go to REQ.
  - From DROP without `imem_rvalid`: stay in DROP with the new `pc`.
  - From DROP with `imem_rvalid`: go to REQ.
- Arithmetic: `pc`+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values: `pc`=`RESET_PC`, state REQ, `armed`=0, `pc_4`=0, `instr`=0, `if_valid`=0, `imem_req`=0 while `rst`=1.
- First `imem_req` with address `RESET_PC` appears in the first cycle after reset deasserts.
- Zero-wait memory (`imem_gnt` in the request cycle, `imem_rvalid` one cycle later):
  - `if_valid` rises 2 cycles after the request cycle.
  - Steady-state throughput is 1 instruction per 2 cycles.
- Redirect in cycle N: `imem_req` with the new address is asserted in N+1 if the FSM is in REQ; otherwise it follows the DROP response.
- `if_valid` falls the cycle after redirect.
- Reset mid-operation: all state returns to reset values immediately. Any `imem_rvalid` arriving after reset for a pre-reset request is the memory's responsibility (memory shares `rst`).

## Structure
- Shared package `if_pkg`: FSM state enum (REQ, WAIT, DROP), `RESET_PC` default, `INSTR_W`=32.
- Single module. No sub-module needed; the output buffer is three registers inline.

## Test plan
- Reset then zero-wait memory returning `instr`=`imem_addr`:
  - Required addresses: BFC00000, BFC00004, BFC00008.
  - Required outputs: `pc_4`=BFC00004/`instr`=BFC00000, then BFC00008/BFC00004, with `if_valid` pulsing every 2 cycles.
- Stall held 5 cycles while `if_valid`=1:
  - `pc_4`/`instr` are stable.
  - At most one further request is granted; its response is not taken until the buffer is free.
  - No data is lost after stall drops.
- `imem_gnt` delayed 3 cycles with `stall` toggling: `imem_req`/`imem_addr` stay constant until grant.
- Redirect to 0x0000_1002 while in WAIT, `imem_rvalid` two cycles later:
  - That response is discarded and `if_valid` stays 0.
  - Next `imem_addr`=0x0000_1000.
- Redirect coincident with `imem_gnt`, and separately with `imem_rvalid`: FSM goes to DROP / REQ respectively, and no stale instruction is output.
- `pc`=FFFFFFFC fetch: `pc_4`=0 and next `imem_addr`=0. Assert `rst` in WAIT: all outputs return to 0 and the first request after reset is `RESET_PC`.
